// File: rtl/secuenciador_tipo_r_if.sv
// Bundles the fetch handshake and the register-file/ALU control lines of the R-type sequencer.
interface secuenciador_tipo_r_if #(
    parameter int ANCHO_CUENTA = 16
) ();
    logic                    instr_valid;
    logic [31:0]             instruccion;
    logic                    instr_ready;
    logic [4:0]              ARead1;
    logic [4:0]              ARead2;
    logic [4:0]              AWR;
    logic [5:0]              operador;
    logic                    lat_op;
    logic                    lat_res;
    logic                    WE;
    logic                    hecho;
    logic                    ilegal;
    logic                    ocupado;
    logic [ANCHO_CUENTA-1:0] cuenta;

    modport master (
        output instr_valid, instruccion,
        input  instr_ready, ARead1, ARead2, AWR, operador,
        input  lat_op, lat_res, WE, hecho, ilegal, ocupado, cuenta
    );

    modport slave (
        input  instr_valid, instruccion,
        output instr_ready, ARead1, ARead2, AWR, operador,
        output lat_op, lat_res, WE, hecho, ilegal, ocupado, cuenta
    );
endinterface

// File: rtl/secuenciador_tipo_r.sv
// Multi-cycle controller stepping one R-type instruction through DECODE, READ, EXEC and WRITE.
// All strobes are decoded from registered state, so they are glitch-free and drop at once on reset.
module secuenciador_tipo_r #(
    parameter int ANCHO_CUENTA = 16
) (
    input logic                  clk,
    input logic                  rst_n,
    secuenciador_tipo_r_if.slave bus
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] DECODE = 3'd1;
    localparam logic [2:0] READ   = 3'd2;
    localparam logic [2:0] EXEC   = 3'd3;
    localparam logic [2:0] WRITE  = 3'd4;

    logic [2:0]              state_q, state_d;
    logic [31:0]             instr_q, instr_d;
    logic [ANCHO_CUENTA-1:0] cuenta_q, cuenta_d;

    logic es_tipo_r;
    logic rd_no_cero;
    logic unused_shamt;

    assign es_tipo_r    = (instr_q[31:26] == 6'b000000);
    assign rd_no_cero   = (instr_q[15:11] != 5'd0);
    assign unused_shamt = ^instr_q[10:6];

    always_comb begin
        state_d  = state_q;
        instr_d  = instr_q;
        cuenta_d = cuenta_q;
        case (state_q)
            IDLE: begin
                if (bus.instr_valid) begin
                    instr_d = bus.instruccion;
                    state_d = DECODE;
                end
            end
            DECODE:  state_d = es_tipo_r ? READ : IDLE;
            READ:    state_d = EXEC;
            EXEC:    state_d = WRITE;
            WRITE: begin
                cuenta_d = cuenta_q + 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            instr_q  <= '0;
            cuenta_q <= '0;
        end else begin
            state_q  <= state_d;
            instr_q  <= instr_d;
            cuenta_q <= cuenta_d;
        end
    end

    assign bus.instr_ready = (state_q == IDLE);
    assign bus.ocupado     = (state_q != IDLE);
    assign bus.ARead1      = instr_q[25:21];
    assign bus.ARead2      = instr_q[20:16];
    assign bus.AWR         = instr_q[15:11];
    assign bus.operador    = instr_q[5:0];
    assign bus.lat_op      = (state_q == READ);
    assign bus.lat_res     = (state_q == EXEC);
    assign bus.WE          = (state_q == WRITE) && rd_no_cero;
    assign bus.hecho       = (state_q == WRITE);
    assign bus.ilegal      = (state_q == DECODE) && !es_tipo_r;
    assign bus.cuenta      = cuenta_q;

endmodule

// File: tb/tb_secuenciador_tipo_r.sv
// Self-checking bench for secuenciador_tipo_r with a 4-bit counter so wrap-around is reachable.
module tb_secuenciador_tipo_r;

    localparam int ANCHO = 4;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    int   exp_cuenta;

    secuenciador_tipo_r_if #(.ANCHO_CUENTA(ANCHO)) bus ();

    secuenciador_tipo_r #(.ANCHO_CUENTA(ANCHO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed strobes packed as {lat_op, lat_res, WE, hecho, ilegal, ocupado, instr_ready}
    function automatic logic [6:0] strb();
        return {bus.lat_op, bus.lat_res, bus.WE, bus.hecho, bus.ilegal, bus.ocupado, bus.instr_ready};
    endfunction

    // Reference timeline: cycle c after the accept edge for a given instruction class
    function automatic logic [6:0] exp_strb(int c, bit legal, bit rdnz);
        if (!legal) return (c == 1) ? 7'b0000110 : 7'b0000001;
        case (c)
            1:       return 7'b0000010;
            2:       return 7'b1000010;
            3:       return 7'b0100010;
            4:       return {2'b00, rdnz, 4'b1010};
            default: return 7'b0000001;
        endcase
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [31:0] word);
        @(negedge clk);
        bus.instr_valid = 1'b1;
        bus.instruccion = word;
        @(posedge clk);
        #1;
        bus.instr_valid = 1'b0;
        bus.instruccion = $urandom;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        exp_cuenta = 0;
        next_cycle();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.instr_valid = 1'b0;
        bus.instruccion = 32'hFFFF_FFFF;
        #1;
        total++;
        if (strb() !== 7'b0000001) begin
            bad++;
            $display("[TB] FAIL reset_strobes got=%b want=%b", strb(), 7'b0000001);
        end
        total++;
        if ({bus.ARead1, bus.ARead2, bus.AWR, bus.operador, bus.cuenta} !== 25'd0) begin
            bad++;
            $display("[TB] FAIL reset_regs got=%h want=0", {bus.ARead1, bus.ARead2, bus.AWR, bus.operador, bus.cuenta});
        end
        @(negedge clk);
        rst_n = 1'b1;
        exp_cuenta = 0;
        next_cycle();
        total++;
        if (bus.ocupado !== 1'b0 || bus.instr_ready !== 1'b1) begin
            bad++;
            $display("[TB] FAIL reset_release ocupado=%b ready=%b want 0/1", bus.ocupado, bus.instr_ready);
        end
    endtask

    task automatic test_add();
        accept(32'h0043_0820);
        total++;
        if ({bus.ARead1, bus.ARead2, bus.AWR, bus.operador} !== {5'd2, 5'd3, 5'd1, 6'h20}) begin
            bad++;
            $display("[TB] FAIL add_fields got=%0d/%0d/%0d/%h want=2/3/1/20", bus.ARead1, bus.ARead2, bus.AWR, bus.operador);
        end
        for (int c = 1; c <= 5; c++) begin
            total++;
            if (strb() !== exp_strb(c, 1'b1, 1'b1)) begin
                bad++;
                $display("[TB] FAIL add_cycle%0d got=%b want=%b", c, strb(), exp_strb(c, 1'b1, 1'b1));
            end
            if (c < 5) next_cycle();
        end
        exp_cuenta = (exp_cuenta + 1) % 16;
        total++;
        if (bus.cuenta !== 4'(exp_cuenta) || bus.AWR !== 5'd1) begin
            bad++;
            $display("[TB] FAIL add_done cuenta=%0d awr=%0d want=%0d/1", bus.cuenta, bus.AWR, exp_cuenta);
        end
    endtask

    task automatic test_rd_zero();
        accept(32'h0043_0022);
        for (int c = 1; c <= 5; c++) begin
            total++;
            if (strb() !== exp_strb(c, 1'b1, 1'b0)) begin
                bad++;
                $display("[TB] FAIL rd0_cycle%0d got=%b want=%b", c, strb(), exp_strb(c, 1'b1, 1'b0));
            end
            if (c < 5) next_cycle();
        end
        exp_cuenta = (exp_cuenta + 1) % 16;
        total++;
        if (bus.cuenta !== 4'(exp_cuenta)) begin
            bad++;
            $display("[TB] FAIL rd0_cuenta got=%0d want=%0d", bus.cuenta, exp_cuenta);
        end
    endtask

    task automatic test_illegal();
        accept(32'h8C22_0004);
        for (int c = 1; c <= 2; c++) begin
            total++;
            if (strb() !== exp_strb(c, 1'b0, 1'b0)) begin
                bad++;
                $display("[TB] FAIL ilegal_cycle%0d got=%b want=%b", c, strb(), exp_strb(c, 1'b0, 1'b0));
            end
            if (c < 2) next_cycle();
        end
        total++;
        if (bus.cuenta !== 4'(exp_cuenta)) begin
            bad++;
            $display("[TB] FAIL ilegal_cuenta got=%0d want=%0d", bus.cuenta, exp_cuenta);
        end
    endtask

    task automatic test_random();
        logic [31:0] word;
        bit          legal;
        int          last;
        for (int n = 0; n < 20; n++) begin
            word = $urandom;
            if ($urandom_range(0, 3) != 0) word[31:26] = 6'd0;
            if ($urandom_range(0, 4) == 0) word[15:11] = 5'd0;
            legal = (word[31:26] == 6'd0);
            last  = legal ? 5 : 2;
            accept(word);
            for (int c = 1; c <= last; c++) begin
                total++;
                if (strb() !== exp_strb(c, legal, word[15:11] != 5'd0)) begin
                    bad++;
                    $display("[TB] FAIL rand%0d_cycle%0d word=%h got=%b want=%b", n, c, word, strb(), exp_strb(c, legal, word[15:11] != 5'd0));
                end
                total++;
                if ({bus.ARead1, bus.ARead2, bus.AWR, bus.operador} !== {word[25:11], word[5:0]}) begin
                    bad++;
                    $display("[TB] FAIL rand%0d_fields word=%h got=%0d/%0d/%0d/%h", n, word, bus.ARead1, bus.ARead2, bus.AWR, bus.operador);
                end
                if (c < last) next_cycle();
            end
            if (legal) exp_cuenta = (exp_cuenta + 1) % 16;
            total++;
            if (bus.cuenta !== 4'(exp_cuenta)) begin
                bad++;
                $display("[TB] FAIL rand%0d_cuenta got=%0d want=%0d", n, bus.cuenta, exp_cuenta);
            end
            repeat ($urandom_range(0, 2)) next_cycle();
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] word;
        logic [31:0] cap;
        int          pos;
        int          last;
        pos  = 0;
        last = 0;
        cap  = {16'd0, bus.AWR, 11'd0};
        for (int n = 0; n < 40; n++) begin
            word = $urandom;
            if ($urandom_range(0, 4) != 0) word[31:26] = 6'd0;
            bus.instr_valid = 1'b1;
            bus.instruccion = word;
            @(posedge clk);
            if (pos == 0) begin
                cap  = word;
                pos  = 1;
                last = (word[31:26] == 6'd0) ? 4 : 1;
            end else if (pos == last) begin
                if (last == 4) exp_cuenta = (exp_cuenta + 1) % 16;
                pos = 0;
            end else begin
                pos++;
            end
            #1;
            total++;
            if (bus.AWR !== cap[15:11] || bus.ocupado !== (pos != 0)) begin
                bad++;
                $display("[TB] FAIL b2b%0d awr=%0d ocupado=%b want=%0d/%b", n, bus.AWR, bus.ocupado, cap[15:11], pos != 0);
            end
            total++;
            if (bus.hecho !== (last == 4 && pos == 4) || bus.WE !== (last == 4 && pos == 4 && cap[15:11] != 5'd0)
                || bus.cuenta !== 4'(exp_cuenta)) begin
                bad++;
                $display("[TB] FAIL b2b%0d_wb hecho=%b we=%b cuenta=%0d want_cuenta=%0d pos=%0d", n, bus.hecho, bus.WE, bus.cuenta, exp_cuenta, pos);
            end
        end
        bus.instr_valid = 1'b0;
        for (int k = 0; k < 6 && pos != 0; k++) begin
            @(posedge clk);
            if (pos == last) begin
                if (last == 4) exp_cuenta = (exp_cuenta + 1) % 16;
                pos = 0;
            end else begin
                pos++;
            end
            #1;
        end
        total++;
        if (bus.instr_ready !== 1'b1 || bus.cuenta !== 4'(exp_cuenta)) begin
            bad++;
            $display("[TB] FAIL b2b_drain ready=%b cuenta=%0d want 1/%0d", bus.instr_ready, bus.cuenta, exp_cuenta);
        end
    endtask

    task automatic test_reset_mid();
        accept(32'h0043_0820);
        next_cycle();
        next_cycle();
        total++;
        if (bus.lat_res !== 1'b1) begin
            bad++;
            $display("[TB] FAIL mid_exec_pre lat_res=%b want=1", bus.lat_res);
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (strb() !== 7'b0000001 || bus.cuenta !== 4'd0) begin
            bad++;
            $display("[TB] FAIL mid_exec_reset strobes=%b cuenta=%0d want=0000001/0", strb(), bus.cuenta);
        end
        @(negedge clk);
        rst_n = 1'b1;
        exp_cuenta = 0;
        next_cycle();
        accept(32'h0043_0820);
        next_cycle();
        next_cycle();
        next_cycle();
        total++;
        if (bus.WE !== 1'b1) begin
            bad++;
            $display("[TB] FAIL mid_write_pre we=%b want=1", bus.WE);
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (bus.WE !== 1'b0 || bus.ocupado !== 1'b0 || bus.instr_ready !== 1'b1) begin
            bad++;
            $display("[TB] FAIL mid_write_reset we=%b ocupado=%b ready=%b want 0/0/1", bus.WE, bus.ocupado, bus.instr_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        next_cycle();
        total++;
        if (bus.cuenta !== 4'd0 || bus.instr_ready !== 1'b1) begin
            bad++;
            $display("[TB] FAIL mid_release cuenta=%0d ready=%b want 0/1", bus.cuenta, bus.instr_ready);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int n = 1; n <= 17; n++) begin
            accept(32'h0043_0820);
            repeat (4) next_cycle();
            exp_cuenta = n % 16;
            total++;
            if (bus.cuenta !== 4'(exp_cuenta)) begin
                bad++;
                $display("[TB] FAIL wrap_after%0d got=%0d want=%0d", n, bus.cuenta, exp_cuenta);
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        exp_cuenta = 0;
        test_reset();
        test_add();
        test_rd_zero();
        test_illegal();
        test_random();
        test_back_to_back();
        test_reset_mid();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
